// File: rtl/ecc_mul_arbiter_if.sv
// Bus bundle between the requesters/multiplier (master side) and ecc_mul_arbiter (slave side).
interface ecc_mul_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int OPW     = 289
);
  logic [NUM_REQ-1:0]     req_valid;
  logic [NUM_REQ-1:0]     req_ready;
  logic [NUM_REQ*OPW-1:0] req_a;
  logic [NUM_REQ*OPW-1:0] req_b;
  logic                   mul_valid;
  logic [OPW-1:0]         mul_a;
  logic [OPW-1:0]         mul_b;
  logic [OPW-1:0]         mul_res;
  logic [NUM_REQ-1:0]     rsp_valid;
  logic [OPW-1:0]         rsp_data;

  modport master (
    output req_valid, req_a, req_b, mul_res,
    input  req_ready, mul_valid, mul_a, mul_b, rsp_valid, rsp_data
  );

  modport slave (
    input  req_valid, req_a, req_b, mul_res,
    output req_ready, mul_valid, mul_a, mul_b, rsp_valid, rsp_data
  );
endinterface

// File: rtl/ecc_mul_arbiter.sv
// Round-robin sharing of one pipelined modular multiplier between NUM_REQ requesters,
// with a latency-matched tag pipeline for result routing and per-requester credits.
module ecc_mul_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int NUM_ELEMENTS = 17,
  parameter int BIT_LEN      = 17,
  parameter int MUL_LATENCY  = 6,
  parameter int MAX_OUT      = 2
) (
  input  logic             clk,
  input  logic             rst,
  ecc_mul_arbiter_if.slave bus,
  output logic             idle
);
  localparam int OPW = NUM_ELEMENTS * BIT_LEN;
  localparam int CW  = $clog2(MAX_OUT + 1);
  localparam int PW  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUT);
  localparam logic [PW-1:0] LAST_ID = PW'(NUM_REQ - 1);

  logic [CW-1:0]      r_cnt [NUM_REQ];
  logic [PW-1:0]      r_ptr;
  logic               r_mul_valid;
  logic [OPW-1:0]     r_mul_a;
  logic [OPW-1:0]     r_mul_b;
  logic [MUL_LATENCY:0] r_tag_v;
  logic [PW-1:0]      r_tag_id [MUL_LATENCY+1];
  logic [NUM_REQ-1:0] r_rsp_valid;
  logic [OPW-1:0]     r_rsp_data;

  logic [NUM_REQ-1:0] w_elig;
  logic [NUM_REQ-1:0] w_grant;
  logic               w_found;
  logic [PW-1:0]      w_gidx;
  logic               w_busy;

  // Eligibility: valid request with a free credit
  always_comb begin
    w_elig = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_elig[i] = bus.req_valid[i] && (r_cnt[i] < MAX_CNT);
    end
  end

  // Round-robin grant: first eligible requester scanning upward from r_ptr
  always_comb begin : p_grant
    int v_idx;
    v_idx   = 0;
    w_grant = '0;
    w_found = 1'b0;
    w_gidx  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      v_idx = int'(r_ptr) + k;
      if (v_idx >= NUM_REQ) begin
        v_idx = v_idx - NUM_REQ;
      end else begin
        v_idx = v_idx;
      end
      if (!w_found && w_elig[v_idx]) begin
        w_found        = 1'b1;
        w_gidx         = PW'(v_idx);
        w_grant[v_idx] = 1'b1;
      end else begin
        w_found = w_found;
      end
    end
  end

  // Pointer advance and operand issue register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr       <= '0;
      r_mul_valid <= 1'b0;
      r_mul_a     <= '0;
      r_mul_b     <= '0;
    end else begin
      r_mul_valid <= w_found;
      if (w_found) begin
        r_ptr   <= (w_gidx == LAST_ID) ? '0 : w_gidx + PW'(1);
        r_mul_a <= bus.req_a[int'(w_gidx)*OPW +: OPW];
        r_mul_b <= bus.req_b[int'(w_gidx)*OPW +: OPW];
      end else begin
        r_ptr   <= r_ptr;
        r_mul_a <= r_mul_a;
        r_mul_b <= r_mul_b;
      end
    end
  end

  // Tag pipeline: last stage lines up with mul_res of the same issue
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tag_v <= '0;
      for (int s = 0; s <= MUL_LATENCY; s++) begin
        r_tag_id[s] <= '0;
      end
    end else begin
      r_tag_v[0]  <= w_found;
      r_tag_id[0] <= w_gidx;
      for (int s = 1; s <= MUL_LATENCY; s++) begin
        r_tag_v[s]  <= r_tag_v[s-1];
        r_tag_id[s] <= r_tag_id[s-1];
      end
    end
  end

  // Registered response: one-hot strobe, data held between results
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rsp_valid <= '0;
      r_rsp_data  <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        r_rsp_valid[i] <= r_tag_v[MUL_LATENCY] && (r_tag_id[MUL_LATENCY] == PW'(i));
      end
      if (r_tag_v[MUL_LATENCY]) begin
        r_rsp_data <= bus.mul_res;
      end else begin
        r_rsp_data <= r_rsp_data;
      end
    end
  end

  // Credits: a grant and a response in the same cycle cancel out
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (w_grant[i] && !r_rsp_valid[i]) begin
          r_cnt[i] <= r_cnt[i] + CW'(1);
        end else if (!w_grant[i] && r_rsp_valid[i]) begin
          r_cnt[i] <= r_cnt[i] - CW'(1);
        end else begin
          r_cnt[i] <= r_cnt[i];
        end
      end
    end
  end

  // Busy while any credit is held or any tag is in flight
  always_comb begin
    w_busy = |r_tag_v;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_busy = w_busy | (r_cnt[i] != '0);
    end
  end

  assign idle          = ~w_busy;
  assign bus.req_ready = w_grant;
  assign bus.mul_valid = r_mul_valid;
  assign bus.mul_a     = r_mul_a;
  assign bus.mul_b     = r_mul_b;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_data  = r_rsp_data;
endmodule

// File: tb/tb_ecc_mul_arbiter.sv
// Directed, table-driven bench for ecc_mul_arbiter with an XOR delay-line multiplier model.
module tb_ecc_mul_arbiter;
  localparam int NR  = 4;
  localparam int OPW = 289;
  localparam int LAT = 6;

  logic clk;
  logic rst;
  logic idle;
  int   checks;
  int   errors;

  ecc_mul_arbiter_if #(.NUM_REQ(NR), .OPW(OPW)) bus ();

  ecc_mul_arbiter #(
    .NUM_REQ(NR), .NUM_ELEMENTS(17), .BIT_LEN(17), .MUL_LATENCY(LAT), .MAX_OUT(2)
  ) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus),
    .idle(idle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Multiplier model: result = a ^ b, LAT cycles after issue
  logic [OPW-1:0] pipe [LAT];
  always_ff @(posedge clk) begin
    pipe[0] <= bus.mul_a ^ bus.mul_b;
    for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
  end
  assign bus.mul_res = pipe[LAT-1];

  typedef struct {
    logic [3:0] vld;
    logic [3:0] rdy;
    logic       mv;
    logic [3:0] rv;
    logic       idl;
    int         mid;
  } vec_t;

  vec_t           tbl [16];
  logic [OPW-1:0] opa [NR];
  logic [OPW-1:0] opb [NR];

  task automatic chk(input string nm, input logic [319:0] act, input logic [319:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic half();
    @(negedge clk);
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    rst           = 1'b1;
    bus.req_valid = '0;
    nxt();
    rst = 1'b0;
  endtask

  function automatic int oh_idx(input logic [3:0] v);
    for (int i = 0; i < 4; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic load_ops();
    for (int i = 0; i < NR; i++) begin
      bus.req_a[i*OPW +: OPW] = opa[i];
      bus.req_b[i*OPW +: OPW] = opb[i];
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    logic [3:0] pv [5];
    logic [3:0] pr [5];
    int         n;
    int         id;
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    for (int i = 0; i < NR; i++) begin
      opa[i] = (OPW'(i + 1) << (17 * (i + 3))) | OPW'(16'hA5A0 + i);
      opb[i] = OPW'(32'h1234_0000 + 3 * i + 7);
    end

    // Round-robin table: all four requesters valid from the first cycle after reset
    tbl[0]  = '{4'hF, 4'h1, 1'b0, 4'h0, 1'b1, -1};
    tbl[1]  = '{4'hF, 4'h2, 1'b1, 4'h0, 1'b0,  0};
    tbl[2]  = '{4'hF, 4'h4, 1'b1, 4'h0, 1'b0,  1};
    tbl[3]  = '{4'hF, 4'h8, 1'b1, 4'h0, 1'b0,  2};
    tbl[4]  = '{4'hF, 4'h1, 1'b1, 4'h0, 1'b0,  3};
    tbl[5]  = '{4'hF, 4'h2, 1'b1, 4'h0, 1'b0,  0};
    tbl[6]  = '{4'hF, 4'h4, 1'b1, 4'h0, 1'b0,  1};
    tbl[7]  = '{4'hF, 4'h8, 1'b1, 4'h0, 1'b0,  2};
    tbl[8]  = '{4'hF, 4'h0, 1'b1, 4'h1, 1'b0,  3};
    tbl[9]  = '{4'hF, 4'h1, 1'b0, 4'h2, 1'b0, -1};
    tbl[10] = '{4'hF, 4'h2, 1'b1, 4'h4, 1'b0,  0};
    tbl[11] = '{4'hF, 4'h4, 1'b1, 4'h8, 1'b0,  1};
    tbl[12] = '{4'hF, 4'h8, 1'b1, 4'h1, 1'b0,  2};
    tbl[13] = '{4'hF, 4'h1, 1'b1, 4'h2, 1'b0,  3};
    tbl[14] = '{4'hF, 4'h2, 1'b1, 4'h4, 1'b0,  0};
    tbl[15] = '{4'hF, 4'h4, 1'b1, 4'h8, 1'b0,  1};

    nxt();
    reset_dut();
    half();
    chk("rst_ready", bus.req_ready, 4'h0);
    chk("rst_mul_valid", bus.mul_valid, 1'b0);
    chk("rst_mul_a", bus.mul_a, '0);
    chk("rst_rsp_valid", bus.rsp_valid, 4'h0);
    chk("rst_rsp_data", bus.rsp_data, '0);
    chk("rst_idle", idle, 1'b1);

    // Single op from requester 2
    nxt();
    bus.req_a = '0;
    bus.req_b = '0;
    bus.req_a[2*OPW +: OPW] = OPW'(1);
    bus.req_b[2*OPW +: OPW] = OPW'(3);
    bus.req_valid = 4'b0100;
    half();
    chk("single_ready", bus.req_ready, 4'b0100);
    nxt();
    bus.req_valid = 4'b0000;
    for (int k = 1; k <= 9; k++) begin
      half();
      chk($sformatf("single_mv_t%0d", k), bus.mul_valid, (k == 1));
      if (k == 1) begin
        chk("single_mul_a", bus.mul_a, OPW'(1));
        chk("single_mul_b", bus.mul_b, OPW'(3));
      end
      chk($sformatf("single_rv_t%0d", k), bus.rsp_valid, (k == 8) ? 4'b0100 : 4'b0000);
      chk($sformatf("single_idle_t%0d", k), idle, (k == 9));
      if (k >= 8) chk($sformatf("single_data_t%0d", k), bus.rsp_data, OPW'(2));
      nxt();
    end

    // Round robin with credits, table-driven
    reset_dut();
    load_ops();
    for (int c = 0; c < 16; c++) begin
      bus.req_valid = tbl[c].vld;
      half();
      chk($sformatf("rr_ready_c%0d", c), bus.req_ready, tbl[c].rdy);
      chk($sformatf("rr_mv_c%0d", c), bus.mul_valid, tbl[c].mv);
      chk($sformatf("rr_rv_c%0d", c), bus.rsp_valid, tbl[c].rv);
      chk($sformatf("rr_idle_c%0d", c), idle, tbl[c].idl);
      if (tbl[c].mid >= 0) begin
        chk($sformatf("rr_mul_a_c%0d", c), bus.mul_a, opa[tbl[c].mid]);
        chk($sformatf("rr_mul_b_c%0d", c), bus.mul_b, opb[tbl[c].mid]);
      end
      id = oh_idx(tbl[c].rv);
      if (id >= 0) chk($sformatf("rr_data_c%0d", c), bus.rsp_data, opa[id] ^ opb[id]);
      nxt();
    end
    bus.req_valid = '0;
    n = 0;
    half();
    while (idle !== 1'b1 && n < 40) begin
      nxt();
      half();
      n++;
    end
    chk("rr_drain_idle", idle, 1'b1);
    nxt();

    // Credit limit on requester 1, including simultaneous inc/dec at T+9
    reset_dut();
    bus.req_valid = 4'b0010;
    for (int k = 0; k < 12; k++) begin
      half();
      chk($sformatf("credit_ready_t%0d", k), bus.req_ready,
          (k <= 1 || k == 9 || k == 10) ? 4'b0010 : 4'b0000);
      chk($sformatf("credit_rv_t%0d", k), bus.rsp_valid,
          (k == 8 || k == 9) ? 4'b0010 : 4'b0000);
      nxt();
    end
    bus.req_valid = '0;

    // Pointer skip and wrap
    reset_dut();
    pv[0] = 4'b0100; pr[0] = 4'b0100;
    pv[1] = 4'b0101; pr[1] = 4'b0001;
    pv[2] = 4'b0100; pr[2] = 4'b0100;
    pv[3] = 4'b1000; pr[3] = 4'b1000;
    pv[4] = 4'b0011; pr[4] = 4'b0001;
    for (int k = 0; k < 5; k++) begin
      bus.req_valid = pv[k];
      half();
      chk($sformatf("ptr_ready_s%0d", k), bus.req_ready, pr[k]);
      nxt();
    end
    bus.req_valid = '0;

    // Reset in flight discards both operations
    reset_dut();
    bus.req_valid = 4'b0001;
    half();
    chk("mid_acc0", bus.req_ready, 4'b0001);
    nxt();
    bus.req_valid = 4'b0010;
    half();
    chk("mid_acc1", bus.req_ready, 4'b0010);
    nxt();
    bus.req_valid = '0;
    nxt();
    nxt();
    rst = 1'b1;
    nxt();
    rst = 1'b0;
    half();
    chk("mid_idle", idle, 1'b1);
    for (int k = 0; k < 12; k++) begin
      half();
      chk($sformatf("mid_no_rsp_%0d", k), bus.rsp_valid, 4'h0);
      nxt();
    end
    bus.req_valid = 4'hF;
    half();
    chk("mid_rr_from0", bus.req_ready, 4'b0001);
    nxt();
    bus.req_valid = '0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
